// File: rtl/sid_pkg.sv
// Shared definitions for the SID audio output stage.
// Contents: sample width, saturation limits, DAC state encoding and a
// 17-bit to 16-bit signed saturation helper.
package sid_pkg;

  localparam int unsigned SID_SAMPLE_W = 16;

  localparam logic signed [SID_SAMPLE_W-1:0] SID_SMAX = 16'sh7FFF;
  localparam logic signed [SID_SAMPLE_W-1:0] SID_SMIN = 16'sh8000;

  typedef enum logic [1:0] {
    SID_IDLE = 2'd0,
    SID_DIFF = 2'd1,
    SID_SAT  = 2'd2,
    SID_OUT  = 2'd3
  } sid_dac_state_t;

  // Clamp a 17-bit signed value into the 16-bit sample range.
  // Overflow is exactly the case where the two top bits disagree.
  function automatic logic signed [SID_SAMPLE_W-1:0] sid_sat17(
    input logic signed [SID_SAMPLE_W:0] v
  );
    if (v[SID_SAMPLE_W] != v[SID_SAMPLE_W-1]) begin
      return v[SID_SAMPLE_W] ? SID_SMIN : SID_SMAX;
    end
    return v[SID_SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/sid_sigma_delta.sv
// First-order sigma-delta modulator for the board audio pin.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   s_i       - signed 16-bit PCM input
//   bit_o     - 1-bit pulse-density output (registered)
// The input is registered as offset binary before entering the
// accumulator, so a change on s_i reaches bit_o two cycles later.
module sid_sigma_delta
  import sid_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [SID_SAMPLE_W-1:0] s_i,
  output logic                           bit_o
);

  logic [SID_SAMPLE_W-1:0] u_q;
  logic [SID_SAMPLE_W-1:0] a_q;
  logic                    bit_q;
  logic [SID_SAMPLE_W:0]   sum_c;

  // Carry out of the accumulator is the output bit.
  assign sum_c = {1'b0, a_q} + {1'b0, u_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      u_q   <= {1'b1, {(SID_SAMPLE_W-1){1'b0}}};  // midscale
      a_q   <= '0;
      bit_q <= 1'b0;
    end else begin
      u_q   <= {~s_i[SID_SAMPLE_W-1], s_i[SID_SAMPLE_W-2:0]};
      a_q   <= sum_c[SID_SAMPLE_W-1:0];
      bit_q <= sum_c[SID_SAMPLE_W];
    end
  end

  assign bit_o = bit_q;

endmodule

// File: rtl/sid_audio_dac.sv
// SID audio output stage: sample capture, optional DC removal,
// saturation, post-reset mute and sigma-delta bitstream generation.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   sample_in         - signed 16-bit sample from the filter/volume block
//   sample_valid      - one-cycle strobe qualifying sample_in
//   sample_out        - processed signed sample, held between updates
//   sample_out_valid  - one-cycle pulse when sample_out updates
//   audio_out         - sigma-delta bitstream
//   muted             - high while the post-reset mute is active
// Build option: define SID_DCBLOCK_EN to include the DC tracker; without
// it dc is zero and the datapath passes samples through unchanged.
module sid_audio_dac
  import sid_pkg::*;
#(
  parameter int unsigned DC_SHIFT    = 10,
  parameter int unsigned MUTE_CYCLES = 65535
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [SID_SAMPLE_W-1:0] sample_in,
  input  logic                           sample_valid,
  output logic signed [SID_SAMPLE_W-1:0] sample_out,
  output logic                           sample_out_valid,
  output logic                           audio_out,
  output logic                           muted
);

  localparam int unsigned Y_W    = SID_SAMPLE_W + 1;
  localparam int unsigned MUTE_W = 20;

  // Reject out-of-range configurations at elaboration.
  if (DC_SHIFT < 4 || DC_SHIFT > 14 || MUTE_CYCLES == 0 ||
      MUTE_CYCLES > 32'd1048575) begin : g_param_check
    $error("sid_audio_dac: DC_SHIFT or MUTE_CYCLES out of range");
  end

  sid_dac_state_t                  state_q, state_d;
  logic                            pend_q;
  logic signed [SID_SAMPLE_W-1:0]  x_hold_q;
  logic signed [SID_SAMPLE_W-1:0]  x_work_q, x_work_d;
  logic signed [Y_W-1:0]           y17_q, y17_d;
  logic signed [SID_SAMPLE_W-1:0]  sample_out_q, sample_out_d;
  logic                            valid_q, valid_d;
  logic signed [Y_W-1:0]           dc_c;
  logic signed [SID_SAMPLE_W-1:0]  y_c;
  logic [MUTE_W-1:0]               mute_cnt_q;
  logic                            muted_q;
  logic signed [SID_SAMPLE_W-1:0]  mod_in_c;

  // Capture: latest strobe wins; a strobe on the IDLE->DIFF edge re-arms pend.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q   <= 1'b0;
      x_hold_q <= '0;
    end else if (sample_valid) begin
      pend_q   <= 1'b1;
      x_hold_q <= sample_in;
    end else if (state_q == SID_IDLE && pend_q) begin
      pend_q   <= 1'b0;
    end
  end

`ifdef SID_DCBLOCK_EN
  localparam int unsigned ACC_W = SID_SAMPLE_W + DC_SHIFT + 1;

  logic signed [ACC_W-1:0] acc_q, acc_d;

  // DC estimate is the leaky integrator scaled down by 2^DC_SHIFT.
  assign dc_c  = Y_W'(acc_q >>> DC_SHIFT);
  assign acc_d = (state_q == SID_SAT) ? acc_q + ACC_W'(y_c) : acc_q;

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end
`else
  assign dc_c = '0;
`endif

  assign y_c = sid_sat17(y17_q);

  // FSM next-state and datapath.
  always_comb begin
    state_d      = state_q;
    x_work_d     = x_work_q;
    y17_d        = y17_q;
    sample_out_d = sample_out_q;
    valid_d      = 1'b0;
    unique case (state_q)
      SID_IDLE: begin
        if (pend_q) begin
          // Snapshot so later strobes cannot disturb the sample in flight.
          x_work_d = x_hold_q;
          state_d  = SID_DIFF;
        end
      end
      SID_DIFF: begin
        y17_d   = Y_W'(x_work_q) - dc_c;
        state_d = SID_SAT;
      end
      SID_SAT: begin
        // Output is registered here so it is visible during OUT.
        sample_out_d = y_c;
        valid_d      = 1'b1;
        state_d      = SID_OUT;
      end
      SID_OUT: begin
        state_d = SID_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SID_IDLE;
      x_work_q     <= '0;
      y17_q        <= '0;
      sample_out_q <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_work_q     <= x_work_d;
      y17_q        <= y17_d;
      sample_out_q <= sample_out_d;
      valid_q      <= valid_d;
    end
  end

  // Post-reset mute; muted_q tracks (mute_cnt_q != 0) as a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      mute_cnt_q <= MUTE_W'(MUTE_CYCLES);
      muted_q    <= 1'b1;
    end else if (mute_cnt_q != '0) begin
      mute_cnt_q <= mute_cnt_q - MUTE_W'(1);
      muted_q    <= (mute_cnt_q != MUTE_W'(1));
    end
  end

  assign mod_in_c = muted_q ? '0 : sample_out_q;

  sid_sigma_delta u_sd (
    .clk   (clk),
    .rst   (rst),
    .s_i   (mod_in_c),
    .bit_o (audio_out)
  );

  assign sample_out       = sample_out_q;
  assign sample_out_valid = valid_q;
  assign muted            = muted_q;

endmodule

// File: tb/tb_sid_audio_dac.sv
// Self-checking bench for sid_audio_dac. Expected samples and their
// arrival cycle are queued when a strobe is driven and compared when
// sample_out_valid pulses. Build with SID_DCBLOCK_EN to cover the DC
// tracker and saturation; without it the bypass/density cases run.
module tb_sid_audio_dac;

  localparam int unsigned DC_SHIFT    = 4;
  localparam int unsigned MUTE_CYCLES = 100;

  typedef struct {
    logic [15:0] val;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_out;
  logic        sample_out_valid;
  logic        audio_out;
  logic        muted;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  exp_t        scb[$];
  logic [15:0] obs[$];
  longint      m_acc   = 0;
  int          ones, bad, muted_n;
  logic        prev_bit;
  logic signed [15:0] last_y;

  sid_audio_dac #(
    .DC_SHIFT    (DC_SHIFT),
    .MUTE_CYCLES (MUTE_CYCLES)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .sample_in        (sample_in),
    .sample_valid     (sample_valid),
    .sample_out       (sample_out),
    .sample_out_valid (sample_out_valid),
    .audio_out        (audio_out),
    .muted            (muted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference processing: y = sat(x - (acc >>> DC_SHIFT)); acc += y.
  function automatic logic [15:0] model_y(input logic [15:0] x);
    longint y;
`ifdef SID_DCBLOCK_EN
    y = longint'($signed(x)) - (m_acc >>> DC_SHIFT);
    if (y > 32767) y = 32767;
    else if (y < -32768) y = -32768;
    m_acc = m_acc + y;
`else
    y = longint'($signed(x));
`endif
    return 16'(y);
  endfunction

  task automatic push(input logic [15:0] x, input int due);
    exp_t e;
    e.val = model_y(x);
    e.due = due;
    scb.push_back(e);
  endtask

  // Drive a one-cycle strobe; if expected, queue its result lat cycles later.
  task automatic strobe(input logic [15:0] x, input bit keep, input int lat);
    @(negedge clk);
    sample_in    = x;
    sample_valid = 1'b1;
    if (keep) push(x, cyc + lat);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sample_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    sample_valid = 1'b0;
    sample_in    = '0;
    repeat (3) @(negedge clk);
    scb.delete();
    obs.delete();
    m_acc = 0;
    check_eq("rst_sample_out", 32'(sample_out), 32'h0);
    check_eq("rst_valid", 32'(sample_out_valid), 32'h0);
    check_eq("rst_audio", 32'(audio_out), 32'h0);
    check_eq("rst_muted", 32'(muted), 32'h1);
    rst = 1'b0;
  endtask

  // Scoreboard: every valid pulse must match the head entry in value and cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (sample_out_valid) begin
        if (scb.size() == 0) begin
          check_eq("spurious_valid", 32'(sample_out), 32'hDEAD_0000);
        end else begin
          e = scb.pop_front();
          check_eq("sample_out", 32'(sample_out), 32'(e.val));
          check_eq("latency", 32'(cyc), 32'(e.due));
          obs.push_back(sample_out);
        end
      end else if (scb.size() != 0 && cyc > scb[0].due) begin
        check_eq("missing_valid", 32'(cyc), 32'(scb[0].due));
        void'(scb.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();

    // Mute window and midscale alternation; 0x7FFF strobed while muted.
    muted_n = 0;
    bad     = 0;
    for (int k = 0; k < 150; k++) begin
      if (k > 0) @(negedge clk);
      if (muted) muted_n++;
      if (k >= 1 && k <= 99 && audio_out !== ((k % 2) == 0)) bad++;
      sample_in    = 16'h7FFF;
      sample_valid = (k == 5);
      if (k == 5) push(16'h7FFF, cyc + 4);
    end
    check_eq("mute_cycles", 32'(muted_n), 32'd100);
    check_eq("mute_alternate", 32'(bad), 32'd0);

    // Full-scale density after mute release.
    ones = 0;
    repeat (65536) begin
      @(negedge clk);
      ones += int'(audio_out);
    end
    check_eq("density_7fff", 32'(ones), 32'd65535);

    // Single sample latency.
    strobe(16'h1234, 1'b1, 4);
    idle(8);

    // Back-to-back strobes: both processed, second four cycles later.
    strobe(16'h0100, 1'b1, 4);
    strobe(16'h0200, 1'b1, 7);
    idle(10);

    // Two strobes while busy: only the later one survives.
    strobe(16'h0300, 1'b1, 4);
    strobe(16'h0400, 1'b0, 0);
    strobe(16'h0500, 1'b1, 6);
    idle(10);

    // Strobe coincident with OUT is not lost.
    strobe(16'h0600, 1'b1, 4);
    idle(3);
    strobe(16'h0700, 1'b1, 4);
    idle(8);

`ifdef SID_DCBLOCK_EN
    // DC ramp: constant input decays toward zero.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      strobe(16'h1000, 1'b1, 4);
      idle(7);
    end
    idle(8);
    check_eq("dc_count", 32'(obs.size()), 32'd400);
    check_eq("dc_first", 32'(obs[0]), 32'h1000);
    check_eq("dc_second", 32'(obs[1]), 32'h0F00);
    bad = 0;
    for (int i = 1; i < obs.size(); i++)
      if ($signed(obs[i]) > $signed(obs[i-1])) bad++;
    check_eq("dc_monotonic", 32'(bad), 32'd0);
    last_y = obs[obs.size()-1];
    check_eq("dc_settled", 32'(last_y >= -16'sd1 && last_y <= 16'sd1), 32'd1);

    // Saturation: settle on full positive, then step to full negative.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      strobe(16'h7FFF, 1'b1, 4);
      idle(3);
    end
    strobe(16'h8000, 1'b1, 4);
    idle(8);
    check_eq("sat_settled", 32'(obs[obs.size()-2]), 32'h0000);
    check_eq("sat_clamp", 32'(obs[obs.size()-1]), 32'h8000);
`else
    // Three-quarter density.
    strobe(16'h4000, 1'b1, 4);
    idle(20);
    ones = 0;
    repeat (4096) begin
      @(negedge clk);
      ones += int'(audio_out);
    end
    check_eq("density_4000", 32'(ones), 32'd3072);

    // Midscale: strict alternation.
    strobe(16'h0000, 1'b1, 4);
    idle(10);
    bad      = 0;
    prev_bit = audio_out;
    repeat (64) begin
      @(negedge clk);
      if (audio_out === prev_bit) bad++;
      prev_bit = audio_out;
    end
    check_eq("alternate_0000", 32'(bad), 32'd0);
`endif

    idle(10);
    check_eq("scb_drained", 32'(scb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
